// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT over one req/ready memory port.
// Define ILLEGAL_TRAP_EN to halt with trap=1 on illegal instructions; otherwise they retire as NOPs.
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic        clk,
  input  logic        arst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic        halted,
  output logic        trap,
  output logic [31:0] pc_out
);
  localparam int unsigned RW = $clog2(NREGS);
  localparam logic [5:0]  NR = 6'(NREGS);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {C_ALU, C_LUI, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_SYS, C_ILL} cls_t;

  state_t      state;
  cls_t        cls, dec_cls;
  logic [31:0] pc, ir, a, b, r, imm, dec_imm;
  logic [31:0] regs [NREGS];
  logic [31:0] op_a, op_b, alu_y, npc, pc_plus4, pc_imm;
  logic        go_fetch, taken, use_rs1, use_rs2, use_rd;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign f3       = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign f7       = ir[31:25];
  assign pc_plus4 = pc + 32'd4;
  assign pc_imm   = pc + imm;
  assign pc_out   = pc;

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    dec_cls = C_ILL;
    dec_imm = {{20{ir[31]}}, ir[31:20]};
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      7'b0110011: begin
        {use_rs1, use_rs2, use_rd} = 3'b111;
        if (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) dec_cls = C_ALU;
      end
      7'b0010011: begin
        {use_rs1, use_rd} = 2'b11;
        if (!((f3 == 3'b001 && f7 != 7'b0) ||
              (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000))) dec_cls = C_ALU;
      end
      7'b0110111: begin
        use_rd  = 1'b1;
        dec_imm = {ir[31:12], 12'b0};
        dec_cls = C_LUI;
      end
      7'b0000011: begin
        {use_rs1, use_rd} = 2'b11;
        if (f3 == 3'b010) dec_cls = C_LOAD;
      end
      7'b0100011: begin
        {use_rs1, use_rs2} = 2'b11;
        dec_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        if (f3 == 3'b010) dec_cls = C_STORE;
      end
      7'b1100011: begin
        {use_rs1, use_rs2} = 2'b11;
        dec_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        if (f3 != 3'b010 && f3 != 3'b011) dec_cls = C_BRANCH;
      end
      7'b1101111: begin
        use_rd  = 1'b1;
        dec_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        dec_cls = C_JAL;
      end
      7'b1110011: dec_cls = C_SYS;
      default: ;
    endcase
    // RV32E: register fields the format actually uses must address an existing register
    if ((use_rs1 && {1'b0, rs1} >= NR) || (use_rs2 && {1'b0, rs2} >= NR) ||
        (use_rd && {1'b0, rd} >= NR)) dec_cls = C_ILL;
  end

  always_comb begin
    op_a  = (cls == C_LUI) ? '0 : a;
    op_b  = (cls == C_ALU && ir[5]) ? b : imm;
    alu_y = op_a + op_b;
    if (cls == C_ALU) begin
      case (f3)
        3'b000:  alu_y = (ir[5] && f7[5]) ? op_a - op_b : op_a + op_b;
        3'b001:  alu_y = op_a << op_b[4:0];
        3'b010:  alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
        3'b011:  alu_y = {31'b0, op_a < op_b};
        3'b100:  alu_y = op_a ^ op_b;
        3'b101:  alu_y = f7[5] ? 32'($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
        3'b110:  alu_y = op_a | op_b;
        default: alu_y = op_a & op_b;
      endcase
    end
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      3'b101:  taken = !($signed(a) < $signed(b));
      3'b110:  taken = (a < b);
      3'b111:  taken = !(a < b);
      default: taken = 1'b0;
    endcase
  end

  // Every path that finishes an instruction funnels through go_fetch: PC update, retire, next fetch.
  always_comb begin
    go_fetch = 1'b0;
    npc      = pc_plus4;
    case (state)
      EXEC: begin
        case (cls)
          C_BRANCH: begin
            go_fetch = 1'b1;
            npc      = taken ? pc_imm : pc_plus4;
          end
          C_JAL: begin
            go_fetch = 1'b1;
            npc      = pc_imm;
          end
`ifdef ILLEGAL_TRAP_EN
          C_ILL: go_fetch = 1'b0;
`else
          C_ILL: go_fetch = 1'b1;
`endif
          default: ;
        endcase
      end
      MEM:     go_fetch = mem_ready && mem_we;
      WB:      go_fetch = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= FETCH;
      cls       <= C_ILL;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      r         <= '0;
      imm       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap_q    <= 1'b0;
`endif
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {pc[31:2], 2'b00};
          end else if (mem_ready) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          a     <= regs[rs1[RW-1:0]];
          b     <= regs[rs2[RW-1:0]];
          imm   <= dec_imm;
          cls   <= dec_cls;
          state <= EXEC;
        end
        EXEC: begin
          case (cls)
            C_ALU, C_LUI: begin
              r     <= alu_y;
              state <= WB;
            end
            C_LOAD, C_STORE: begin
              r        <= alu_y;
              mem_req  <= 1'b1;
              mem_we   <= (cls == C_STORE);
              mem_addr <= {alu_y[31:2], 2'b00};
              if (cls == C_STORE) mem_wdata <= b;
              state    <= MEM;
            end
            C_JAL: if (rd != 5'd0) regs[rd[RW-1:0]] <= pc_plus4;
            C_SYS: begin
              state  <= HALT;
              halted <= 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            C_ILL: begin
              state  <= HALT;
              halted <= 1'b1;
              trap_q <= 1'b1;
            end
`else
            C_ILL: ;
`endif
            default: ;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              r     <= mem_rdata;
              state <= WB;
            end
          end
        end
        WB:      if (rd != 5'd0) regs[rd[RW-1:0]] <= r;
        HALT:    halted <= 1'b1;
        default: state <= FETCH;
      endcase
      if (go_fetch) begin
        pc       <= npc;
        retire   <= 1'b1;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= {npc[31:2], 2'b00};
        state    <= FETCH;
      end
    end
  end
endmodule
